gol_pattern_loader: RTL and testbench
=====================================

Name: gol_pattern_loader

Overview:
- Transmitter side of the game-of-life button programming interface.
- Takes a 49-bit seed pattern and plays it into the grid datapath as a timed sequence of btn0/btn1 pulses while holding prgm asserted.
- Lets a host or self-test preload the 7x7 board without manual button presses.
- Sits beside the game FSM/datapath top; its outputs drive the prgm, btn0 and btn1 inputs, and it watches game_state.

Parameters:
- CELLS, 49, number of grid cells transmitted; bit index 0 is sent first.
- GAP_CYCLES, 3, idle cycles after each button pulse (must be >= 1).
- TIMEOUT, 255, maximum REQ cycles spent waiting for program state before aborting with error.

Ports:
- clka  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request a load; sampled only in IDLE.
- abort  in  1  terminate a load in progress.
- pattern  in  CELLS  seed pattern; latched on the accepted start.
- game_state  in  2  current game FSM state.
- prgm  out  1  program-mode request to the game FSM.
- btn0  out  1  one-cycle pulse meaning "write 0 to current cell".
- btn1  out  1  one-cycle pulse meaning "write 1 to current cell".
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion strobe.
- err  out  1  valid with done: 1 means timeout or abort.
- grid_rb  in  CELLS  grid readback; present only with GOL_LOADER_VERIFY_EN.
- load_err  out  1  readback mismatch flag; present only with GOL_LOADER_VERIFY_EN.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, all outputs 0, bit index 0, gap counter 0, timeout counter 0.
- All outputs are registered.
- States:
  - IDLE: on start=1 and abort=0, latch pattern, clear index and counters, go to REQ. start while busy is ignored.
  - REQ: prgm=1. If game_state==GS_PRGM is sampled, go to PULSE. Otherwise increment the timeout counter; when it reaches TIMEOUT, go to DONE with err=1.
  - PULSE (1 cycle): prgm=1, btn1=pat[idx], btn0=~pat[idx]. Exactly one of btn0/btn1 is high. Go to GAP.
  - GAP (GAP_CYCLES cycles): prgm=1, btn0=btn1=0.
    - At the end: if idx==CELLS-1, go to RELEASE.
    - Otherwise increment idx and go to PULSE.
  - RELEASE (1 cycle): prgm=0, buttons 0. Go to DONE.
  - DONE (1 cycle): done=1, err held at its recorded value, busy=1. Go to IDLE, clearing err on exit.
- abort=1 in REQ, PULSE or GAP: next state is RELEASE with err=1. A pulse already on the outputs completes its single cycle. abort in RELEASE, DONE or IDLE has no effect.
- Simultaneous start and abort in IDLE: abort wins; stay in IDLE.
- If game_state leaves GS_PRGM during PULSE/GAP: treat as abort (RELEASE, err=1).
- Latency, with start at cycle 0 and game_state already GS_PRGM:
  - REQ at cycle 1.
  - First pulse at cycle 2.
  - Pulse k at cycle 2+k*(1+GAP_CYCLES).
  - done at cycle 3+CELLS*(1+GAP_CYCLES); 199 for defaults.
- Counter widths: idx is clog2(CELLS); the gap and timeout counters are sized from their parameters. No counter wraps, since each is cleared on state entry.

Optional Feature:
- GOL_LOADER_VERIFY_EN defined:
  - Adds the grid_rb input and the load_err output.
  - In RELEASE, when err=0, the block compares grid_rb against the latched pattern. load_err is registered and is valid with done: 1 on any bit mismatch.
  - load_err is forced to 0 on aborted or timed-out loads, and cleared on the next accepted start or on reset.
- Not defined: neither port exists, and no comparator is built.

Decomposition:
- Package gol_pkg:
  - Game state encodings GS_IDLE=2'b00, GS_PRGM=2'b01, GS_RUN=2'b10, GS_PAUSE=2'b11.
  - GRID_CELLS=49.
  - Loader state enum.
- Sub-module gol_btn_pulser: holds the PULSE/GAP timing. Takes a "send bit" request and a bit value; returns the btn0/btn1 pulse and a ready flag.
- The top loader FSM owns REQ, index, timeout and abort handling.

Test Plan:
- Single full load:
  - Stimulus: pattern=49'h1_5555_5555_5555, game_state=GS_PRGM, start at cycle 0.
  - Response: 49 pulses at cycles 2+4k; btn1 on even k, btn0 on odd k; prgm high in cycles 1-197; done=1, err=0 at cycle 199.
- Delayed entry:
  - Stimulus: game_state=GS_IDLE for 10 cycles after start, then GS_PRGM.
  - Response: first pulse exactly 2 cycles after GS_PRGM is first sampled.
- Timeout:
  - Stimulus: game_state never reaches GS_PRGM.
  - Response: no button pulses; done=1, err=1 at cycle 257 (1 + TIMEOUT + 1); prgm low in that done cycle.
- Abort during GAP after pulse 5:
  - Response: RELEASE next cycle, done with err=1; no further pulses; a new start is then accepted normally.
- Reset mid-load (rst_n low for 1 cycle at pulse 20):
  - Response: all outputs 0 the next cycle, IDLE, no done strobe.
  - start ignored while busy: a second start at pulse 10 does not alter the sequence.
- With GOL_LOADER_VERIFY_EN:
  - grid_rb equal to pattern: load_err=0 at done.
  - grid_rb with bit 48 flipped: load_err=1 at done.

Source files
------------

// File: rtl/gol_pkg.sv
// Shared encodings for the game-of-life pattern loader and its button pulser.
package gol_pkg;

  localparam logic [1:0] GS_IDLE  = 2'b00;
  localparam logic [1:0] GS_PRGM  = 2'b01;
  localparam logic [1:0] GS_RUN   = 2'b10;
  localparam logic [1:0] GS_PAUSE = 2'b11;

  localparam int unsigned GRID_CELLS = 49;

  typedef enum logic [2:0] {
    LS_IDLE,
    LS_REQ,
    LS_SEND,
    LS_RELEASE,
    LS_DONE
  } loader_state_t;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_PULSE,
    PS_GAP
  } pulser_state_t;

  typedef struct packed {
    logic prgm;
    logic busy;
    logic done;
    logic err;
  } loader_ctl_t;

endpackage

// File: rtl/gol_btn_pulser.sv
// Turns a send-bit request into one btn0/btn1 pulse followed by GAP_CYCLES idle cycles.
module gol_btn_pulser
  import gol_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 3
) (
  input  logic clka,
  input  logic rst_n,
  input  logic clr,
  input  logic send,
  input  logic bit_val,
  output logic btn0,
  output logic btn1,
  output logic ready_c
);

  localparam int unsigned CNT_W = $clog2(GAP_CYCLES + 1);

  pulser_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn0_d, btn1_d;
  logic             gap_last;

  // Ready in the last gap cycle so back-to-back bits need no extra idle cycle.
  assign gap_last = (cnt_q == CNT_W'(GAP_CYCLES - 1));
  assign ready_c  = (state_q == PS_IDLE) || ((state_q == PS_GAP) && gap_last);

  always_ff @(posedge clka) begin
    if (!rst_n) begin
      state_q <= PS_IDLE;
      cnt_q   <= '0;
      btn0    <= 1'b0;
      btn1    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      btn0    <= btn0_d;
      btn1    <= btn1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    btn0_d  = 1'b0;
    btn1_d  = 1'b0;
    if (clr) begin
      state_d = PS_IDLE;
      cnt_d   = '0;
    end else if (send && ready_c) begin
      state_d = PS_PULSE;
      cnt_d   = '0;
      btn1_d  = bit_val;
      btn0_d  = ~bit_val;
    end else begin
      case (state_q)
        PS_PULSE: begin
          state_d = PS_GAP;
          cnt_d   = '0;
        end
        PS_GAP: begin
          if (gap_last) begin
            state_d = PS_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/gol_pattern_loader.sv
// Plays a seed pattern into the game grid as btn0/btn1 pulses under prgm.
// Optional readback check of the loaded grid: define GOL_LOADER_VERIFY_EN.
module gol_pattern_loader
  import gol_pkg::*;
#(
  parameter int unsigned CELLS      = GRID_CELLS,
  parameter int unsigned GAP_CYCLES = 3,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic             clka,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CELLS-1:0] pattern,
  input  logic [1:0]       game_state,
`ifdef GOL_LOADER_VERIFY_EN
  input  logic [CELLS-1:0] grid_rb,
  output logic             load_err,
`endif
  output logic             prgm,
  output logic             btn0,
  output logic             btn1,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned IDX_W = $clog2(CELLS);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  loader_state_t    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CELLS-1:0] pat_q, pat_d;
  logic             err_q, err_d;
  loader_ctl_t      ctl_q, ctl_d;
  logic             send_c, clr_c, ready_c, send_bit_c, in_prgm_c;
`ifdef GOL_LOADER_VERIFY_EN
  logic             load_err_d;
`endif

  assign in_prgm_c  = (game_state == GS_PRGM);
  assign send_bit_c = pat_q[idx_d];

  gol_btn_pulser #(
    .GAP_CYCLES (GAP_CYCLES)
  ) u_pulser (
    .clka    (clka),
    .rst_n   (rst_n),
    .clr     (clr_c),
    .send    (send_c),
    .bit_val (send_bit_c),
    .btn0    (btn0),
    .btn1    (btn1),
    .ready_c (ready_c)
  );

  always_ff @(posedge clka) begin
    if (!rst_n) begin
      state_q  <= LS_IDLE;
      idx_q    <= '0;
      tmo_q    <= '0;
      pat_q    <= '0;
      err_q    <= 1'b0;
      ctl_q    <= '0;
`ifdef GOL_LOADER_VERIFY_EN
      load_err <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      pat_q    <= pat_d;
      err_q    <= err_d;
      ctl_q    <= ctl_d;
`ifdef GOL_LOADER_VERIFY_EN
      load_err <= load_err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    pat_d   = pat_q;
    err_d   = err_q;
    send_c  = 1'b0;
    clr_c   = 1'b0;
    ctl_d   = '0;
`ifdef GOL_LOADER_VERIFY_EN
    load_err_d = load_err;
`endif
    case (state_q)
      LS_IDLE: begin
        if (start && !abort) begin
          state_d = LS_REQ;
          pat_d   = pattern;
          idx_d   = '0;
          tmo_d   = '0;
          err_d   = 1'b0;
`ifdef GOL_LOADER_VERIFY_EN
          load_err_d = 1'b0;
`endif
        end
      end
      LS_REQ: begin
        if (abort) begin
          state_d = LS_RELEASE;
          err_d   = 1'b1;
        end else if (in_prgm_c) begin
          state_d = LS_SEND;
          send_c  = 1'b1;
        end else if (tmo_q == TMO_W'(TIMEOUT)) begin
          state_d = LS_DONE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      // Losing program mode mid-sequence is handled exactly like an abort.
      LS_SEND: begin
        if (abort || !in_prgm_c) begin
          state_d = LS_RELEASE;
          err_d   = 1'b1;
          clr_c   = 1'b1;
        end else if (ready_c) begin
          if (idx_q == IDX_W'(CELLS - 1)) begin
            state_d = LS_RELEASE;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            send_c = 1'b1;
          end
        end
      end
      LS_RELEASE: begin
        state_d = LS_DONE;
`ifdef GOL_LOADER_VERIFY_EN
        load_err_d = !err_q && (grid_rb != pat_q);
`endif
      end
      LS_DONE: begin
        state_d = LS_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = LS_IDLE;
    endcase

    ctl_d.prgm = (state_d == LS_REQ) || (state_d == LS_SEND);
    ctl_d.busy = (state_d != LS_IDLE);
    ctl_d.done = (state_d == LS_DONE);
    ctl_d.err  = (state_d == LS_DONE) && err_d;
  end

  assign prgm = ctl_q.prgm;
  assign busy = ctl_q.busy;
  assign done = ctl_q.done;
  assign err  = ctl_q.err;

endmodule

// File: tb/tb_gol_pattern_loader.sv
// Scoreboard bench for gol_pattern_loader; expected output vectors are queued per cycle.
// Readback-check scenarios are included when GOL_LOADER_VERIFY_EN is defined.
module tb_gol_pattern_loader;
  import gol_pkg::*;

  localparam int unsigned CELLS  = 49;
  localparam int unsigned STRIDE = 4;
  localparam int unsigned SEQ    = CELLS * STRIDE;

  // Vector layout: {load_err, prgm, btn0, btn1, busy, done, err}
  localparam logic [6:0] V_REQ    = 7'b0100100;
  localparam logic [6:0] V_REL    = 7'b0000100;
  localparam logic [6:0] V_DONE_E = 7'b0000111;

  logic             clka = 1'b0;
  logic             rst_n, start, abort;
  logic [CELLS-1:0] pattern;
  logic [1:0]       game_state;
  logic             prgm, btn0, btn1, busy, done, err;
`ifdef GOL_LOADER_VERIFY_EN
  logic [CELLS-1:0] grid_rb;
  logic             load_err;
`endif

  int         vectors     = 0;
  int         miscompares = 0;
  logic [6:0] exp_q[$];

  always #5 clka = ~clka;

  gol_pattern_loader dut (
    .clka       (clka),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .pattern    (pattern),
    .game_state (game_state),
`ifdef GOL_LOADER_VERIFY_EN
    .grid_rb    (grid_rb),
    .load_err   (load_err),
`endif
    .prgm       (prgm),
    .btn0       (btn0),
    .btn1       (btn1),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  function automatic logic [6:0] obs_vec();
`ifdef GOL_LOADER_VERIFY_EN
    return {load_err, prgm, btn0, btn1, busy, done, err};
`else
    return {1'b0, prgm, btn0, btn1, busy, done, err};
`endif
  endfunction

  function automatic logic [CELLS-1:0] rand_pat();
    return CELLS'({$urandom(), $urandom()});
  endfunction

  // Expected cycles 1..fp+198 of a clean load whose first pulse lands in cycle fp.
  function automatic void push_load(logic [CELLS-1:0] pat, int fp, logic le);
    for (int n = 1; n <= fp + int'(SEQ) + 2; n++) begin
      if (n < fp) begin
        exp_q.push_back(V_REQ);
      end else if (n < fp + int'(SEQ)) begin
        int   k;
        logic p;
        k = (n - fp) / int'(STRIDE);
        p = ((n - fp) % int'(STRIDE)) == 0;
        exp_q.push_back({1'b0, 1'b1, p & ~pat[k], p & pat[k], 1'b1, 2'b00});
      end else if (n == fp + int'(SEQ)) begin
        exp_q.push_back(V_REL);
      end else if (n == fp + int'(SEQ) + 1) begin
        exp_q.push_back({le, 6'b000110});
      end else begin
        exp_q.push_back({le, 6'b000000});
      end
    end
  endfunction

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] e, o;
    int n = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; pattern = '0; game_state = GS_IDLE;
`ifdef GOL_LOADER_VERIFY_EN
    grid_rb = '0;
`endif
    repeat (4) exp_q.push_back(7'b0);
    while (exp_q.size() > 0) begin
      step(); n++;
      if (n == 2) rst_n = 1'b1;
      e = exp_q.pop_front(); o = obs_vec(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset cyc %0d: got %b want %b", n, o, e);
      end
    end
  endtask

  task automatic test_full_load();
    logic [6:0] e, o;
    int n = 0;
    pattern = 49'h1_5555_5555_5555; game_state = GS_PRGM; start = 1'b1;
`ifdef GOL_LOADER_VERIFY_EN
    grid_rb = pattern;
`endif
    push_load(pattern, 2, 1'b0);
    while (exp_q.size() > 0) begin
      step(); n++;
      start = 1'b0;
      e = exp_q.pop_front(); o = obs_vec(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL full_load cyc %0d: got %b want %b", n, o, e);
      end
    end
  endtask

  task automatic test_delayed_entry();
    logic [6:0] e, o;
    int n = 0;
    pattern = rand_pat(); game_state = GS_IDLE; start = 1'b1;
`ifdef GOL_LOADER_VERIFY_EN
    grid_rb = pattern;
`endif
    push_load(pattern, 12, 1'b0);
    while (exp_q.size() > 0) begin
      step(); n++;
      start = 1'b0;
      if (n == 11) game_state = GS_PRGM;
      e = exp_q.pop_front(); o = obs_vec(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL delayed_entry cyc %0d: got %b want %b", n, o, e);
      end
    end
  endtask

  task automatic test_timeout();
    logic [6:0] e, o;
    int n = 0;
    pattern = rand_pat(); game_state = GS_RUN; start = 1'b1;
    repeat (256) exp_q.push_back(V_REQ);
    exp_q.push_back(V_DONE_E);
    exp_q.push_back(7'b0);
    while (exp_q.size() > 0) begin
      step(); n++;
      start = 1'b0;
      e = exp_q.pop_front(); o = obs_vec(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL timeout cyc %0d: got %b want %b", n, o, e);
      end
    end
  endtask

  task automatic test_abort_gap();
    logic [6:0] e, o;
    int n = 0;
    pattern = rand_pat(); game_state = GS_PRGM; start = 1'b1;
    push_load(pattern, 2, 1'b0);
    while (exp_q.size() > 23) void'(exp_q.pop_back());
    exp_q.push_back(V_REL);
    exp_q.push_back(V_DONE_E);
    exp_q.push_back(7'b0);
    while (exp_q.size() > 0) begin
      step(); n++;
      start = 1'b0;
      if (n == 23) abort = 1'b1;
      if (n == 24) abort = 1'b0;
      e = exp_q.pop_front(); o = obs_vec(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL abort_gap cyc %0d: got %b want %b", n, o, e);
      end
    end
    n = 0;
    pattern = rand_pat(); start = 1'b1;
`ifdef GOL_LOADER_VERIFY_EN
    grid_rb = pattern;
`endif
    push_load(pattern, 2, 1'b0);
    while (exp_q.size() > 0) begin
      step(); n++;
      start = 1'b0;
      e = exp_q.pop_front(); o = obs_vec(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL abort_restart cyc %0d: got %b want %b", n, o, e);
      end
    end
  endtask

  task automatic test_state_loss();
    logic [6:0] e, o;
    int n = 0;
    pattern = rand_pat(); game_state = GS_PRGM; start = 1'b1;
    push_load(pattern, 2, 1'b0);
    while (exp_q.size() > 11) void'(exp_q.pop_back());
    exp_q.push_back(V_REL);
    exp_q.push_back(V_DONE_E);
    exp_q.push_back(7'b0);
    while (exp_q.size() > 0) begin
      step(); n++;
      start = 1'b0;
      if (n == 11) game_state = GS_RUN;
      e = exp_q.pop_front(); o = obs_vec(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL state_loss cyc %0d: got %b want %b", n, o, e);
      end
    end
    game_state = GS_PRGM;
  endtask

  task automatic test_start_abort_idle();
    logic [6:0] e, o;
    int n = 0;
    pattern = rand_pat(); start = 1'b1; abort = 1'b1;
    repeat (4) exp_q.push_back(7'b0);
    while (exp_q.size() > 0) begin
      step(); n++;
      start = 1'b0; abort = 1'b0;
      e = exp_q.pop_front(); o = obs_vec(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL start_abort_idle cyc %0d: got %b want %b", n, o, e);
      end
    end
  endtask

  task automatic test_reset_midload();
    logic [6:0] e, o;
    int n = 0;
    pattern = rand_pat(); game_state = GS_PRGM; start = 1'b1;
    push_load(pattern, 2, 1'b0);
    while (exp_q.size() > 82) void'(exp_q.pop_back());
    repeat (8) exp_q.push_back(7'b0);
    while (exp_q.size() > 0) begin
      step(); n++;
      start = (n == 42);
      if (n == 82) rst_n = 1'b0;
      if (n == 83) rst_n = 1'b1;
      e = exp_q.pop_front(); o = obs_vec(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset_midload cyc %0d: got %b want %b", n, o, e);
      end
    end
  endtask

`ifdef GOL_LOADER_VERIFY_EN
  task automatic test_verify();
    logic [6:0] e, o;
    int n = 0;
    pattern = rand_pat(); game_state = GS_PRGM; start = 1'b1;
    grid_rb = pattern;
    grid_rb[48] = ~grid_rb[48];
    push_load(pattern, 2, 1'b1);
    while (exp_q.size() > 0) begin
      step(); n++;
      start = 1'b0;
      e = exp_q.pop_front(); o = obs_vec(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL verify_mismatch cyc %0d: got %b want %b", n, o, e);
      end
    end
    n = 0;
    pattern = rand_pat(); grid_rb = pattern; start = 1'b1;
    push_load(pattern, 2, 1'b0);
    while (exp_q.size() > 0) begin
      step(); n++;
      start = 1'b0;
      e = exp_q.pop_front(); o = obs_vec(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL verify_match cyc %0d: got %b want %b", n, o, e);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_load();
    test_delayed_entry();
    test_timeout();
    test_abort_gap();
    test_state_loss();
    test_start_abort_idle();
    test_reset_midload();
`ifdef GOL_LOADER_VERIFY_EN
    test_verify();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
